// File: rtl/l2_command_sequencer.sv
// l2_command_sequencer: trace-record front end for the L2 cache.
// Accepts {command, address} records over valid/ready and queues them in a
// 4-entry circular FIFO. Cache operations (codes 0-6) are issued one at a time
// over request/done. Code 8 pulses clearCache and code 9 pulses printRequest.
// Optional feature macro: L2_SEQ_STATS_EN adds saturating hit/miss statistics.
module l2_command_sequencer #(
  parameter int indexBits = 14,
  parameter int tagBits   = 12,
  parameter int depthBits = 2,
  parameter int countBits = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inValid,
  input  logic [3:0]                   inCommand,
  input  logic [tagBits+indexBits-1:0] inAddress,
  output logic                         inReady,
  output logic                         illegalCommand,
  output logic                         cacheRequest,
  output logic [3:0]                   cacheCommand,
  output logic [tagBits+indexBits-1:0] cacheAddress,
  input  logic                         cacheDone,
  input  logic                         cacheHit,
  output logic                         clearCache,
  output logic                         printRequest,
  output logic                         busy
`ifdef L2_SEQ_STATS_EN
  ,
  output logic [countBits-1:0]         readCount,
  output logic [countBits-1:0]         writeCount,
  output logic [countBits-1:0]         hitCount,
  output logic [countBits-1:0]         missCount,
  output logic [countBits-1:0]         snoopCount
`endif
);

  localparam int addr_w  = tagBits + indexBits;
  localparam int entry_w = 4 + addr_w;
  localparam int depth   = 1 << depthBits;
  localparam logic [depthBits:0] full_count = {1'b1, {depthBits{1'b0}}};

  typedef enum logic {
    st_idle,
    st_req
  } state_t;

  // FIFO storage and bookkeeping
  logic [entry_w-1:0]   fifo_mem [depth];
  logic [depthBits-1:0] wr_ptr_reg;
  logic [depthBits-1:0] rd_ptr_reg;
  logic [depthBits:0]   count_reg;

  // Sequencer state and registered outputs
  state_t              state_reg;
  logic                req_reg;
  logic [3:0]          cmd_reg;
  logic [addr_w-1:0]   addr_reg;
  logic                clear_reg;
  logic                print_reg;
  logic                illegal_reg;

  logic                full;
  logic                legal_cmd;
  logic                push;
  logic                pop;
  logic [entry_w-1:0]  head;
  logic [3:0]          head_cmd;
  logic [addr_w-1:0]   head_addr;

  // Only 0-6, 8 and 9 are meaningful; everything else is dropped at the door
  always_comb begin
    legal_cmd = 1'b0;
    if (inCommand <= 4'd6 || inCommand == 4'd8 || inCommand == 4'd9) begin
      legal_cmd = 1'b1;
    end
  end

  // Ready comes from the registered count, so a same-cycle pop never frees a slot early
  assign full      = (count_reg == full_count);
  assign inReady   = !full;
  assign push      = inValid && !full && legal_cmd;
  assign pop       = (state_reg == st_idle) && (count_reg != '0);
  assign head      = fifo_mem[rd_ptr_reg];
  assign head_cmd  = head[entry_w-1:addr_w];
  assign head_addr = head[addr_w-1:0];

  // FIFO payload write; storage needs no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {inCommand, inAddress};
    end
  end

  // Pointer and occupancy update; pointers wrap naturally modulo depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // One-cycle flag for a rejected command code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= inValid && !full && !legal_cmd;
    end
  end

  // Issue FSM: pops in IDLE, holds the request in REQ until the cache finishes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= st_idle;
      req_reg   <= 1'b0;
      cmd_reg   <= '0;
      addr_reg  <= '0;
      clear_reg <= 1'b0;
      print_reg <= 1'b0;
    end else begin
      clear_reg <= 1'b0;
      print_reg <= 1'b0;
      case (state_reg)
        st_idle: begin
          if (pop) begin
            if (head_cmd <= 4'd6) begin
              cmd_reg   <= head_cmd;
              addr_reg  <= head_addr;
              req_reg   <= 1'b1;
              state_reg <= st_req;
            end else if (head_cmd == 4'd8) begin
              clear_reg <= 1'b1;
            end else if (head_cmd == 4'd9) begin
              print_reg <= 1'b1;
            end
          end
        end
        st_req: begin
          if (cacheDone) begin
            req_reg   <= 1'b0;
            state_reg <= st_idle;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= st_idle;
        end
      endcase
    end
  end

  assign cacheRequest   = req_reg;
  assign cacheCommand   = cmd_reg;
  assign cacheAddress   = addr_reg;
  assign clearCache     = clear_reg;
  assign printRequest   = print_reg;
  assign illegalCommand = illegal_reg;
  assign busy           = (count_reg != '0) || (state_reg != st_idle);

`ifdef L2_SEQ_STATS_EN
  // Counter order: 0 read, 1 write, 2 hit, 3 miss, 4 snoop
  logic [4:0]           stat_inc;
  logic                 stat_clear;
  logic                 op_complete;
  logic [countBits-1:0] stat_cnt [5];

  assign op_complete = (state_reg == st_req) && cacheDone;
  assign stat_clear  = pop && (head_cmd == 4'd8);

  // Decode which counters step on the completion edge of the current operation
  always_comb begin
    stat_inc = '0;
    if (op_complete) begin
      case (cmd_reg)
        4'd0, 4'd2: begin
          stat_inc[0] = 1'b1;
          stat_inc[2] = cacheHit;
          stat_inc[3] = !cacheHit;
        end
        4'd1: begin
          stat_inc[1] = 1'b1;
          stat_inc[2] = cacheHit;
          stat_inc[3] = !cacheHit;
        end
        4'd3, 4'd4, 4'd5, 4'd6: stat_inc[4] = 1'b1;
        default: stat_inc = '0;
      endcase
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_stat
    logic [countBits-1:0] cnt_reg;

    // Saturating counter, zeroed when a clear command is popped
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (stat_clear) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign stat_cnt[gi] = cnt_reg;
  end

  assign readCount  = stat_cnt[0];
  assign writeCount = stat_cnt[1];
  assign hitCount   = stat_cnt[2];
  assign missCount  = stat_cnt[3];
  assign snoopCount = stat_cnt[4];
`else
  // Hit flag only matters to the statistics block
  logic unused_hit;
  assign unused_hit = cacheHit;
`endif

endmodule

// File: tb/tb_l2_command_sequencer.sv
// Directed testbench for l2_command_sequencer (statistics checked when
// L2_SEQ_STATS_EN is defined).
module tb_l2_command_sequencer;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic [3:0]  inCommand;
  logic [25:0] inAddress;
  logic        inReady;
  logic        illegalCommand;
  logic        cacheRequest;
  logic [3:0]  cacheCommand;
  logic [25:0] cacheAddress;
  logic        cacheDone;
  logic        cacheHit;
  logic        clearCache;
  logic        printRequest;
  logic        busy;
`ifdef L2_SEQ_STATS_EN
  logic [31:0] readCount, writeCount, hitCount, missCount, snoopCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  l2_command_sequencer dut (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inCommand(inCommand), .inAddress(inAddress),
    .inReady(inReady), .illegalCommand(illegalCommand),
    .cacheRequest(cacheRequest), .cacheCommand(cacheCommand),
    .cacheAddress(cacheAddress), .cacheDone(cacheDone), .cacheHit(cacheHit),
    .clearCache(clearCache), .printRequest(printRequest), .busy(busy)
`ifdef L2_SEQ_STATS_EN
    , .readCount(readCount), .writeCount(writeCount), .hitCount(hitCount),
    .missCount(missCount), .snoopCount(snoopCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input logic [3:0] c, input logic [25:0] a);
    inValid   = 1'b1;
    inCommand = c;
    inAddress = a;
    tick();
    inValid   = 1'b0;
  endtask

  task automatic finish_req(input string tag);
    cacheDone = 1'b1;
    tick();
    cacheDone = 1'b0;
    check(tag, {31'd0, cacheRequest}, 32'd0);
  endtask

  task automatic expect_issue(input string tag, input logic [3:0] c, input logic [25:0] a);
    tick();
    check({tag, "_req"},  {31'd0, cacheRequest}, 32'd1);
    check({tag, "_cmd"},  {28'd0, cacheCommand}, {28'd0, c});
    check({tag, "_addr"}, {6'd0, cacheAddress},  {6'd0, a});
  endtask

  task automatic run_op(input logic [3:0] c, input logic [25:0] a, input logic hit);
    push_rec(c, a);
    tick();
    cacheDone = 1'b1;
    cacheHit  = hit;
    tick();
    cacheDone = 1'b0;
    cacheHit  = 1'b0;
  endtask

  logic [25:0] addrs [10];

  initial begin
    reset = 1'b1; inValid = 1'b0; inCommand = '0; inAddress = '0;
    cacheDone = 1'b0; cacheHit = 1'b0;
    addrs[0] = 26'h3FFFFFF; addrs[1] = 26'h0000000; addrs[2] = 26'h2AAAAAA;
    addrs[3] = 26'h1555555; addrs[4] = 26'h0000001; addrs[5] = 26'h0000000;
    addrs[6] = 26'h3FFFFFF; addrs[7] = 26'h0ABCDEF; addrs[8] = 26'h3000000;
    addrs[9] = 26'h0000FFF;

    // Reset state
    tick(); tick();
    check("rst_inReady", {31'd0, inReady}, 32'd1);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_req",     {31'd0, cacheRequest}, 32'd0);
    check("rst_cmd",     {28'd0, cacheCommand}, 32'd0);
    check("rst_addr",    {6'd0, cacheAddress}, 32'd0);
    check("rst_clear",   {31'd0, clearCache}, 32'd0);
    check("rst_print",   {31'd0, printRequest}, 32'd0);
    check("rst_illegal", {31'd0, illegalCommand}, 32'd0);
`ifdef L2_SEQ_STATS_EN
    check("rst_read", readCount, 32'd0);
    check("rst_snoop", snoopCount, 32'd0);
`endif
    reset = 1'b0;
    $display("reset released");

    // Single operation with cacheDone tied high: one-cycle request
    cacheDone = 1'b1;
    push_rec(4'd0, 26'h0000123);
    check("t1_req_push_edge", {31'd0, cacheRequest}, 32'd0);
    check("t1_busy_push_edge", {31'd0, busy}, 32'd1);
    tick();
    check("t1_req_issue", {31'd0, cacheRequest}, 32'd1);
    check("t1_addr", {6'd0, cacheAddress}, 32'h0000123);
    tick();
    check("t1_req_done", {31'd0, cacheRequest}, 32'd0);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    cacheDone = 1'b0;
    $display("t1 single op addr=0000123 done");

    // Fill while the cache stalls; fifth queued push is refused
    push_rec(4'd0, 26'h0000A00);
    tick();
    check("t2_r0_req", {31'd0, cacheRequest}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t2_ready_before_%0d", i), {31'd0, inReady}, 32'd1);
      push_rec(4'(i), 26'h0000A00 + 26'(i));
    end
    check("t2_full_ready", {31'd0, inReady}, 32'd0);
    push_rec(4'd5, 26'h0000BAD);
    check("t2_still_full", {31'd0, inReady}, 32'd0);
    check("t2_r0_held", {6'd0, cacheAddress}, 32'h0000A00);
    for (int i = 1; i <= 4; i++) begin
      finish_req($sformatf("t2_gap_%0d", i));
      if (i == 1) check("t2_ready_no_pop_yet", {31'd0, inReady}, 32'd0);
      expect_issue($sformatf("t2_r%0d", i), 4'(i), 26'h0000A00 + 26'(i));
      if (i == 1) check("t2_ready_after_pop", {31'd0, inReady}, 32'd1);
    end
    finish_req("t2_last_done");
    tick();
    check("t2_no_fifth_req", {31'd0, cacheRequest}, 32'd0);
    check("t2_idle_busy", {31'd0, busy}, 32'd0);
    $display("t2 full/backpressure order done");

    // Illegal code then print: pulses only, no cache traffic
    push_rec(4'd7, 26'h0000077);
    check("t3_illegal_pulse", {31'd0, illegalCommand}, 32'd1);
    check("t3_illegal_busy", {31'd0, busy}, 32'd0);
    push_rec(4'd9, 26'h0000099);
    check("t3_illegal_drop", {31'd0, illegalCommand}, 32'd0);
    check("t3_print_not_yet", {31'd0, printRequest}, 32'd0);
    tick();
    check("t3_print_pulse", {31'd0, printRequest}, 32'd1);
    check("t3_no_req", {31'd0, cacheRequest}, 32'd0);
    tick();
    check("t3_print_drop", {31'd0, printRequest}, 32'd0);
    check("t3_no_req2", {31'd0, cacheRequest}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);
    $display("t3 illegal/print done");

    // Two fill/drain rounds exercising pointer wrap and extreme addresses
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) push_rec(4'((r * 5 + i) % 7), addrs[r * 5 + i]);
      check($sformatf("t6_round%0d_full", r), {31'd0, inReady}, 32'd0);
      check($sformatf("t6_round%0d_r0", r), {6'd0, cacheAddress}, {6'd0, addrs[r * 5]});
      for (int i = 1; i < 5; i++) begin
        finish_req($sformatf("t6_round%0d_gap%0d", r, i));
        expect_issue($sformatf("t6_round%0d_r%0d", r, i), 4'((r * 5 + i) % 7), addrs[r * 5 + i]);
      end
      finish_req($sformatf("t6_round%0d_last", r));
      tick();
      check($sformatf("t6_round%0d_busy", r), {31'd0, busy}, 32'd0);
      $display("t6 wrap round %0d done", r);
    end

    // Reset while a request is outstanding with three records queued
    for (int i = 0; i < 4; i++) push_rec(4'd1, 26'h0000C00 + 26'(i));
    check("t5_req_before", {31'd0, cacheRequest}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_req_async", {31'd0, cacheRequest}, 32'd0);
    check("t5_ready_async", {31'd0, inReady}, 32'd1);
    check("t5_busy_async", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t5_no_stale_%0d", i), {31'd0, cacheRequest}, 32'd0);
    end
    check("t5_busy_after", {31'd0, busy}, 32'd0);
    $display("t5 reset mid-transaction done");

    // Statistics then clear
    run_op(4'd0, 26'h0000010, 1'b1);
    run_op(4'd1, 26'h0000011, 1'b0);
    run_op(4'd2, 26'h0000012, 1'b1);
    run_op(4'd4, 26'h0000014, 1'b1);
`ifdef L2_SEQ_STATS_EN
    check("t4_read", readCount, 32'd2);
    check("t4_write", writeCount, 32'd1);
    check("t4_hit", hitCount, 32'd2);
    check("t4_miss", missCount, 32'd1);
    check("t4_snoop", snoopCount, 32'd1);
`endif
    push_rec(4'd8, 26'h0000000);
    check("t4_clear_not_yet", {31'd0, clearCache}, 32'd0);
    tick();
    check("t4_clear_pulse", {31'd0, clearCache}, 32'd1);
    check("t4_clear_no_req", {31'd0, cacheRequest}, 32'd0);
`ifdef L2_SEQ_STATS_EN
    check("t4_read_zero", readCount, 32'd0);
    check("t4_hit_zero", hitCount, 32'd0);
    check("t4_miss_zero", missCount, 32'd0);
    check("t4_write_zero", writeCount, 32'd0);
    check("t4_snoop_zero", snoopCount, 32'd0);
`endif
    tick();
    check("t4_clear_drop", {31'd0, clearCache}, 32'd0);
    $display("t4 statistics/clear done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
